ped_crossing_ctrl: RTL and testbench
====================================

# ped_crossing_ctrl

Parametrised pelican-crossing controller and the successor to our fixed four-state, one-cycle-per-phase crossing light. It sequences car and pedestrian lamps through five timed phases with a programmable duration per phase and an enforced minimum car-green time. It latches pedestrian requests and drives a countdown for a pedestrian display. It sits between the debounced push-button input and the lamp drivers.

## Interface
- CNT_W, 8: width of the phase timer and countdown output; must hold max(T_*) - 1.
- T_GREEN, 10: minimum car-green duration in cycles (≥1).
- T_CY, 3: car-yellow duration in cycles (≥1).
- T_PY, 2: pedestrian-ready duration (car red, ped yellow) in cycles (≥1).
- T_PG, 8: pedestrian-green duration in cycles (≥1).
- T_CLR, 2: all-red clearance duration after pedestrian green, in cycles (≥1).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  1  pedestrian request, already synchronised and debounced, level-sampled.
- green_c, yellow_c, red_c  out  1 each  car lamps, one-hot.
- green_p, yellow_p, red_p  out  1 each  pedestrian lamps, one-hot.
- ped_wait  out  1  request latched and not yet served ("WAIT" lamp).
- ped_count  out  CNT_W  remaining pedestrian-green cycles minus one; 0 outside PED_GREEN.

## Operation
- States: CAR_GREEN, CAR_YELLOW, PED_READY, PED_GREEN, CLEAR. Encoding is free; lamps are decoded from the registered state only (no button-to-lamp combinational path).
- Lamp map:
  - CAR_GREEN: green_c, red_p.
  - CAR_YELLOW: yellow_c, red_p.
  - PED_READY: red_c, yellow_p.
  - PED_GREEN: red_c, green_p.
  - CLEAR: red_c, red_p.
- Phase timer: on entry to a state it loads T_state - 1. It decrements by 1 each cycle and saturates at 0.
- Transitions:
  - CAR_GREEN → CAR_YELLOW when timer == 0 and req_q == 1. Otherwise CAR_GREEN holds indefinitely, with the timer parked at 0.
  - CAR_YELLOW → PED_READY, PED_READY → PED_GREEN, PED_GREEN → CLEAR and CLEAR → CAR_GREEN each occur when timer == 0.
  - Every phase except an unrequested CAR_GREEN lasts exactly T cycles.
- Request latch req_q:
  - Set at any edge where button == 1 and the state is not PED_GREEN.
  - Cleared at the edge that enters PED_GREEN.
  - Presses during PED_GREEN are ignored.
  - Presses during CLEAR are latched and serve the next cycle of the sequence.
  - ped_wait = req_q.
- ped_count equals the timer value while in PED_GREEN, otherwise 0.
- Illegal or unreachable state encodings go to CAR_GREEN on the next edge, with the timer loaded to T_GREEN - 1.

## Timing
- Reset (asynchronous assert, any time, including mid-phase):
  - State CAR_GREEN, timer T_GREEN - 1, req_q 0.
  - Outputs: green_c = 1, red_p = 1, all other lamps 0, ped_wait = 0, ped_count = 0.
- Reset release: minimum green applies from the first edge after rst_n rises.
- Button high sampled at edge k during CAR_GREEN with the timer already 0:
  - ped_wait = 1 after edge k.
  - yellow_c = 1 after edge k+1.
- Button held continuously: behaves as a single request. After CLEAR, if button is still high, req_q re-latches and a new sequence follows after the minimum green.
- Button press and entry to PED_GREEN on the same edge: the clear wins and req_q = 0.
- Full sequence length, from leaving CAR_GREEN to re-entering it: T_CY + T_PY + T_PG + T_CLR cycles (15 with defaults).

## Test plan
- Reset hold, then release with button = 0 for 50 cycles → green_c/red_p remain 1 throughout; ped_wait = 0.
- Button pulsed one cycle at cycle 2 after reset (defaults):
  - ped_wait rises after the next edge.
  - yellow_c asserts at cycle 10.
  - Phases last 3/2/8/2 cycles.
  - ped_count reads 7 down to 0 during PED_GREEN.
  - green_c returns at cycle 25.
- Button pulsed at cycle 40 with the timer long expired → yellow_c at cycle 41; minimum green is not re-imposed.
- Button pulsed during PED_GREEN → ped_wait stays 0; no second sequence follows.
- Button pulsed during CLEAR → ped_wait = 1; after CLEAR, exactly T_GREEN cycles of green, then CAR_YELLOW.
- rst_n asserted mid-PED_GREEN → immediately green_c = 1, red_p = 1, ped_count = 0, ped_wait = 0.
- Rerun the second scenario with T_GREEN = 1, T_PG = 255 → exact phase lengths hold; no CNT_W overflow.

Source files
------------

// File: rtl/ped_crossing_ctrl_if.sv
// Lamp and push-button bundle between the crossing controller and its surroundings.
// The slave side is the controller; the master side drives the button and watches the lamps.
interface ped_crossing_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             button;
  logic             green_c;
  logic             yellow_c;
  logic             red_c;
  logic             green_p;
  logic             yellow_p;
  logic             red_p;
  logic             ped_wait;
  logic [CNT_W-1:0] ped_count;

  modport master (
    output button,
    input  green_c, yellow_c, red_c, green_p, yellow_p, red_p, ped_wait, ped_count
  );

  modport slave (
    input  button,
    output green_c, yellow_c, red_c, green_p, yellow_p, red_p, ped_wait, ped_count
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pelican-crossing controller: five timed phases, latched pedestrian request,
// enforced minimum car-green time and a pedestrian-green countdown.
//
// state      | meaning
// CAR_GREEN  | cars go; waits for min green and a latched request
// CAR_YELLOW | cars warned to stop
// PED_READY  | cars red, pedestrians get ready (ped yellow)
// PED_GREEN  | pedestrians cross; ped_count counts down
// CLEAR      | all red before cars resume
module ped_crossing_ctrl #(
  parameter int CNT_W   = 8,
  parameter int T_GREEN = 10,
  parameter int T_CY    = 3,
  parameter int T_PY    = 2,
  parameter int T_PG    = 8,
  parameter int T_CLR   = 2
) (
  input  logic clk,
  input  logic rst_n,
  ped_crossing_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    PED_READY  = 3'd2,
    PED_GREEN  = 3'd3,
    CLEAR      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LD_GREEN = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_CY    = CNT_W'(T_CY - 1);
  localparam logic [CNT_W-1:0] LD_PY    = CNT_W'(T_PY - 1);
  localparam logic [CNT_W-1:0] LD_PG    = CNT_W'(T_PG - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             req_q, req_d;
  logic             tc;

  assign tc = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAR_GREEN;
      timer_q <= LD_GREEN;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = tc ? '0 : timer_q - 1'b1;
    unique case (state_q)
      CAR_GREEN: begin
        if (tc && req_q) begin
          state_d = CAR_YELLOW;
          timer_d = LD_CY;
        end
      end
      CAR_YELLOW: begin
        if (tc) begin
          state_d = PED_READY;
          timer_d = LD_PY;
        end
      end
      PED_READY: begin
        if (tc) begin
          state_d = PED_GREEN;
          timer_d = LD_PG;
        end
      end
      PED_GREEN: begin
        if (tc) begin
          state_d = CLEAR;
          timer_d = LD_CLR;
        end
      end
      CLEAR: begin
        if (tc) begin
          state_d = CAR_GREEN;
          timer_d = LD_GREEN;
        end
      end
      default: begin
        state_d = CAR_GREEN;
        timer_d = LD_GREEN;
      end
    endcase

    // Entering PED_GREEN serves the request and beats a coincident press.
    req_d = req_q;
    if (state_d == PED_GREEN && state_q != PED_GREEN) begin
      req_d = 1'b0;
    end else if (bus.button && state_q != PED_GREEN) begin
      req_d = 1'b1;
    end
  end

  always_comb begin
    bus.green_c   = 1'b0;
    bus.yellow_c  = 1'b0;
    bus.red_c     = 1'b0;
    bus.green_p   = 1'b0;
    bus.yellow_p  = 1'b0;
    bus.red_p     = 1'b0;
    bus.ped_wait  = req_q;
    bus.ped_count = '0;
    unique case (state_q)
      CAR_GREEN: begin
        bus.green_c = 1'b1;
        bus.red_p   = 1'b1;
      end
      CAR_YELLOW: begin
        bus.yellow_c = 1'b1;
        bus.red_p    = 1'b1;
      end
      PED_READY: begin
        bus.red_c    = 1'b1;
        bus.yellow_p = 1'b1;
      end
      PED_GREEN: begin
        bus.red_c     = 1'b1;
        bus.green_p   = 1'b1;
        bus.ped_count = timer_q;
      end
      CLEAR: begin
        bus.red_c = 1'b1;
        bus.red_p = 1'b1;
      end
      default: begin
        bus.green_c = 1'b1;
        bus.red_p   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Random-press bench for two controller configurations, scored cycle by cycle
// against a phase/elapsed-time model of the crossing.
module tb_ped_crossing_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   btn = 1'b0;
  always #5 clk = ~clk;

  ped_crossing_ctrl_if #(.CNT_W(8)) if0 ();
  ped_crossing_ctrl_if #(.CNT_W(8)) if1 ();

  ped_crossing_ctrl u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  ped_crossing_ctrl #(.T_GREEN(1), .T_PG(255)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_checks = 0;
  int n_pass   = 0;
  int n_resets = 0;

  // Phase durations per instance: green, car yellow, ped ready, ped green, clear.
  int durs [2][5] = '{'{10, 3, 2, 8, 2}, '{1, 3, 2, 255, 2}};
  // Lamps {gc, yc, rc, gp, yp, rp} per phase.
  logic [5:0] lamp_tbl [5] = '{6'b100001, 6'b010001, 6'b001010, 6'b001100, 6'b001001};
  localparam logic [14:0] RESET_OUT = {6'b100001, 1'b0, 8'd0};

  int phase [2];
  int el    [2];
  bit req   [2];
  logic [14:0] q0 [$];
  logic [14:0] q1 [$];

  function automatic logic [14:0] expect_of(int m);
    logic [7:0] cnt;
    cnt = (phase[m] == 3) ? 8'(durs[m][3] - 1 - el[m]) : 8'd0;
    return {lamp_tbl[phase[m]], req[m], cnt};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      phase[m] = 0;
      el[m]    = 0;
      req[m]   = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock edge: a phase ends after exactly its duration, except car green
  // which additionally waits for a latched request.
  task automatic model_step(int m, bit b);
    bit last, leave;
    int nxt;
    last  = (el[m] >= durs[m][phase[m]] - 1);
    leave = last && (phase[m] != 0 || req[m]);
    nxt   = leave ? (phase[m] + 1) % 5 : phase[m];
    if (nxt == 3 && phase[m] != 3) req[m] = 1'b0;
    else if (b && phase[m] != 3)   req[m] = 1'b1;
    if (leave)      el[m] = 0;
    else if (!last) el[m] = el[m] + 1;
    phase[m] = nxt;
  endtask

  function automatic logic [14:0] actual0();
    return {if0.green_c, if0.yellow_c, if0.red_c, if0.green_p, if0.yellow_p, if0.red_p,
            if0.ped_wait, if0.ped_count};
  endfunction

  function automatic logic [14:0] actual1();
    return {if1.green_c, if1.yellow_c, if1.red_c, if1.green_p, if1.yellow_p, if1.red_p,
            if1.ped_wait, if1.ped_count};
  endfunction

  task automatic check(string name, logic [14:0] got, logic [14:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: lamps/wait/count got %b_%b_%0d want %b_%b_%0d",
                  name, $time, got[14:9], got[8], got[7:0], want[14:9], want[8], want[7:0]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (q0.size() > 0) check("dut0_cycle", actual0(), q0.pop_front());
      if (q1.size() > 0) check("dut1_cycle", actual1(), q1.pop_front());
    end
  end

  initial begin
    if0.button = 1'b0;
    if1.button = 1'b0;
    model_reset();
    #1;
    check("dut0_reset", actual0(), RESET_OUT);
    check("dut1_reset", actual1(), RESET_OUT);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step(0, btn);
      model_step(1, btn);
      q0.push_back(expect_of(0));
      q1.push_back(expect_of(1));
      @(negedge clk);
      if (cyc < 50)                                        btn = 1'b0;
      else if ((cyc >= 600 && cyc < 700) || (cyc >= 2000 && cyc < 2400)) btn = 1'b1;
      else                                                 btn = ($urandom_range(0, 19) == 0);
      if0.button = btn;
      if1.button = btn;
      // Asynchronous reset mid-crossing, away from any clock edge.
      if (phase[0] == 3 && el[0] == 3 && n_resets < 2 && cyc > 800) begin
        n_resets++;
        #2 rst_n = 1'b0;
        #1;
        check("dut0_midreset", actual0(), RESET_OUT);
        check("dut1_midreset", actual1(), RESET_OUT);
        model_reset();
        @(posedge clk);
        #1;
        check("dut0_inreset", actual0(), RESET_OUT);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
